// File: rtl/clk_mode_sequencer_pkg.sv
// Shared types and constants for the CPU clock-mode sequencer.
// Divider codes select /1, /2, /4 or /8 in the clock/reset manager.
package clk_mode_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    GATE,
    SWITCH,
    UNGATE,
    RELEASE,
    DONE
  } state_e;

  localparam logic [2:0] DIV_1   = 3'd0;
  localparam logic [2:0] DIV_2   = 3'd1;
  localparam logic [2:0] DIV_4   = 3'd2;
  localparam logic [2:0] DIV_8   = 3'd3;
  localparam logic [2:0] DIV_MAX = DIV_8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clk_mode_sequencer_if.sv
// Requester-side bus: per-requester valid/payload held until the one-hot ready pulse.
// Payload is sampled in the same cycle ready is high.
interface clk_mode_sequencer_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_div_sel;
  logic [NUM_REQ-1:0]   req_gate;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_div_sel,
    output req_gate,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_div_sel,
    input  req_gate,
    output req_ready
  );

endinterface

// File: rtl/clk_mode_sequencer_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at/after the pointer, combinationally.
// Pointer moves past the winner only when the grant is consumed (advance).
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk_ref,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    j         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/clk_mode_sequencer.sv
// Sequences CPU clock divider/gate changes: quiesce, gate, switch, settle, ungate, release.
// Accept->done is 2+GATE_CYC+(SETTLE_CYC+1)+GATE_CYC+1 cycles with immediate ack; one request in flight.
module clk_mode_sequencer
  import clk_mode_sequencer_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int GATE_CYC        = 4,
  parameter int SETTLE_CYC      = 16,
  parameter int QUIESCE_TIMEOUT = 256
) (
  input  logic                       clk_ref,
  input  logic                       rst,
  input  logic                       rst_done,
  input  logic                       test_mode,
  clk_mode_sequencer_if.slave        req_if,
  output logic                       cpu_quiesce_req,
  input  logic                       cpu_quiesce_ack,
  output logic                       clk_gate_en,
  output logic [2:0]                 clk_div_sel,
  output logic                       busy,
  output logic                       done_pulse,
  output logic                       err_timeout,
  output logic                       err_cfg,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int CNT_W = $clog2(max3(GATE_CYC, SETTLE_CYC, QUIESCE_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(QUIESCE_TIMEOUT - 1);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q;
  logic [2:0]                   lat_div_q;
  logic                         lat_gate_q;
  logic [NUM_REQ-1:0]           grant;
  logic [$clog2(NUM_REQ)-1:0]   grant_idx;
  logic                         accept;
  logic [2:0]                   sel_div;
  logic                         sel_gate;
  logic                         gate_set, gate_load, div_load, to_set;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_ref   (clk_ref),
    .rst       (rst),
    .req       (req_if.req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept = !rst && rst_done && !test_mode && (state_q == IDLE) && (|req_if.req_valid);
  assign req_if.req_ready = accept ? grant : '0;

  always_comb begin
    sel_div  = '0;
    sel_gate = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_div  = req_if.req_div_sel[3*k +: 3];
        sel_gate = req_if.req_gate[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gate_set  = 1'b0;
    gate_load = 1'b0;
    div_load  = 1'b0;
    to_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && (sel_div <= DIV_MAX)) begin
          state_d = (sel_div == clk_div_sel && sel_gate == clk_gate_en) ? DONE : QUIESCE;
        end
      end
      QUIESCE: begin
        if (cpu_quiesce_ack) begin
          state_d  = GATE;
          gate_set = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          to_set  = 1'b1;
        end
      end
      GATE: begin
        if (cnt_q == GATE_LAST) state_d = SWITCH;
      end
      // New code drives from the second SWITCH cycle, then stays stable SETTLE_CYC cycles while gated.
      SWITCH: begin
        div_load = (cnt_q == '0);
        if (cnt_q == SETTLE_END) begin
          state_d   = UNGATE;
          gate_load = 1'b1;
        end
      end
      UNGATE: begin
        if (cnt_q == GATE_LAST) state_d = RELEASE;
      end
      RELEASE: begin
        if (!cpu_quiesce_ack) begin
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          to_set  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cpu_quiesce_req = (state_q == QUIESCE) || (state_q == GATE) ||
                           (state_q == SWITCH)  || (state_q == UNGATE);
  assign busy       = (state_q != IDLE);
  assign done_pulse = (state_q == DONE);

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_div_q   <= '0;
      lat_gate_q  <= 1'b0;
      clk_gate_en <= 1'b0;
      clk_div_sel <= '0;
      err_timeout <= 1'b0;
      err_cfg     <= 1'b0;
      owner       <= '0;
    end else if (!rst_done) begin
      // Abort: same as reset but the owner (and arbiter pointer) survive.
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_div_q   <= '0;
      lat_gate_q  <= 1'b0;
      clk_gate_en <= 1'b0;
      clk_div_sel <= '0;
      err_timeout <= 1'b0;
      err_cfg     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
      err_cfg <= accept && (sel_div > DIV_MAX);
      if (accept) begin
        lat_div_q   <= sel_div;
        lat_gate_q  <= sel_gate;
        owner       <= grant_idx;
        err_timeout <= 1'b0;
      end
      if (to_set)    err_timeout <= 1'b1;
      if (gate_set)  clk_gate_en <= 1'b1;
      if (gate_load) clk_gate_en <= lat_gate_q;
      if (div_load)  clk_div_sel <= lat_div_q;
    end
  end

endmodule

// File: tb/tb_clk_mode_sequencer.sv
// Directed bench for clk_mode_sequencer: hand-timed steps, immediate-assertion checks.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_clk_mode_sequencer;

  logic       clk_ref;
  logic       rst;
  logic       rst_done;
  logic       test_mode;
  logic       cpu_quiesce_req;
  logic       cpu_quiesce_ack;
  logic       clk_gate_en;
  logic [2:0] clk_div_sel;
  logic       busy;
  logic       done_pulse;
  logic       err_timeout;
  logic       err_cfg;
  logic [0:0] owner;

  int checks = 0;
  int errors = 0;

  clk_mode_sequencer_if #(.NUM_REQ(2)) req_if ();

  clk_mode_sequencer #(
    .NUM_REQ(2), .GATE_CYC(4), .SETTLE_CYC(16), .QUIESCE_TIMEOUT(256)
  ) dut (
    .clk_ref         (clk_ref),
    .rst             (rst),
    .rst_done        (rst_done),
    .test_mode       (test_mode),
    .req_if          (req_if),
    .cpu_quiesce_req (cpu_quiesce_req),
    .cpu_quiesce_ack (cpu_quiesce_ack),
    .clk_gate_en     (clk_gate_en),
    .clk_div_sel     (clk_div_sel),
    .busy            (busy),
    .done_pulse      (done_pulse),
    .err_timeout     (err_timeout),
    .err_cfg         (err_cfg),
    .owner           (owner)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_ref);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] d, input logic g);
    req_if.req_valid[i]          = v;
    req_if.req_div_sel[3*i +: 3] = d;
    req_if.req_gate[i]           = g;
  endtask

  initial begin
    rst = 1'b1; rst_done = 1'b1; test_mode = 1'b0; cpu_quiesce_ack = 1'b0;
    req_if.req_valid = '0; req_if.req_div_sel = '0; req_if.req_gate = '0;

    // Reset: everything low, no ready even with a valid request.
    tick(2);
    set_req(0, 1'b1, 3'd2, 1'b0);
    #1;
    chk("rst_ready", {30'd0, req_if.req_ready}, 32'd0);
    chk("rst_qreq", {31'd0, cpu_quiesce_req}, 32'd0);
    chk("rst_gate", {31'd0, clk_gate_en}, 32'd0);
    chk("rst_div", {29'd0, clk_div_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_errs", {29'd0, done_pulse, err_timeout, err_cfg}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    set_req(0, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    tick(1);

    // 1) req0 div=2 gate=0, ack arrives in the third QUIESCE cycle.
    set_req(0, 1'b1, 3'd2, 1'b0);
    #1;
    chk("t1_ready", {30'd0, req_if.req_ready}, 32'd1);
    tick(1);
    set_req(0, 1'b0, 3'd2, 1'b0);
    chk("t1_qreq", {31'd0, cpu_quiesce_req}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_owner", {31'd0, owner}, 32'd0);
    tick(2);
    chk("t1_wait_gate", {31'd0, clk_gate_en}, 32'd0);
    cpu_quiesce_ack = 1'b1;
    tick(1);
    chk("t1_gated", {31'd0, clk_gate_en}, 32'd1);
    chk("t1_div_old", {29'd0, clk_div_sel}, 32'd0);
    tick(4);
    chk("t1_switch_entry_div", {29'd0, clk_div_sel}, 32'd0);
    tick(1);
    chk("t1_div_new", {29'd0, clk_div_sel}, 32'd2);
    chk("t1_gate_hold", {31'd0, clk_gate_en}, 32'd1);
    tick(15);
    chk("t1_settle_end_gate", {31'd0, clk_gate_en}, 32'd1);
    tick(1);
    chk("t1_ungate", {31'd0, clk_gate_en}, 32'd0);
    chk("t1_ungate_qreq", {31'd0, cpu_quiesce_req}, 32'd1);
    tick(4);
    chk("t1_release_qreq", {31'd0, cpu_quiesce_req}, 32'd0);
    chk("t1_release_done", {31'd0, done_pulse}, 32'd0);
    cpu_quiesce_ack = 1'b0;
    tick(1);
    chk("t1_done", {31'd0, done_pulse}, 32'd1);
    tick(1);
    chk("t1_idle", {29'd0, done_pulse, busy, err_timeout}, 32'd0);
    chk("t1_final_div", {29'd0, clk_div_sel}, 32'd2);

    // 2) Pointer back to 0; both valid. Ack held high -> full latency of 28.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t2_rst_div", {29'd0, clk_div_sel}, 32'd0);
    set_req(0, 1'b1, 3'd1, 1'b0);
    set_req(1, 1'b1, 3'd3, 1'b1);
    cpu_quiesce_ack = 1'b1;
    #1;
    chk("t2_ready0", {30'd0, req_if.req_ready}, 32'd1);
    tick(1);
    set_req(0, 1'b0, 3'd1, 1'b0);
    chk("t2_owner0", {31'd0, owner}, 32'd0);
    chk("t2_no_ready_busy", {30'd0, req_if.req_ready}, 32'd0);
    tick(26);
    chk("t2_c27_done", {31'd0, done_pulse}, 32'd0);
    chk("t2_c27_qreq", {31'd0, cpu_quiesce_req}, 32'd0);
    cpu_quiesce_ack = 1'b0;
    tick(1);
    chk("t2_latency_done", {31'd0, done_pulse}, 32'd1);
    chk("t2_no_ready_done", {30'd0, req_if.req_ready}, 32'd0);
    tick(1);
    chk("t2_ready1", {30'd0, req_if.req_ready}, 32'd2);
    chk("t2_cfg0", {28'd0, clk_gate_en, clk_div_sel}, 32'h1);
    tick(1);
    set_req(1, 1'b0, 3'd3, 1'b1);
    cpu_quiesce_ack = 1'b1;
    chk("t2_owner1", {31'd0, owner}, 32'd1);
    tick(26);
    cpu_quiesce_ack = 1'b0;
    tick(1);
    chk("t2_done1", {31'd0, done_pulse}, 32'd1);
    tick(1);
    chk("t2_cfg1", {28'd0, clk_gate_en, clk_div_sel}, 32'hb);
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // 3) Ack never rises: quiesce_req held 256 cycles, then timeout.
    set_req(0, 1'b1, 3'd0, 1'b0);
    #1;
    chk("t3_ready", {30'd0, req_if.req_ready}, 32'd1);
    tick(1);
    set_req(0, 1'b0, 3'd0, 1'b0);
    tick(255);
    chk("t3_qreq_256", {31'd0, cpu_quiesce_req}, 32'd1);
    chk("t3_err_pending", {31'd0, err_timeout}, 32'd0);
    tick(1);
    chk("t3_qreq_drop", {31'd0, cpu_quiesce_req}, 32'd0);
    chk("t3_err_timeout", {31'd0, err_timeout}, 32'd1);
    chk("t3_idle", {31'd0, busy}, 32'd0);
    chk("t3_cfg_kept", {28'd0, clk_gate_en, clk_div_sel}, 32'hb);

    // 4) Illegal divider from req1, then a no-change request from req0.
    set_req(1, 1'b1, 3'd5, 1'b0);
    #1;
    chk("t4_ready_bad", {30'd0, req_if.req_ready}, 32'd2);
    tick(1);
    set_req(1, 1'b0, 3'd5, 1'b0);
    chk("t4_err_cfg", {31'd0, err_cfg}, 32'd1);
    chk("t4_no_qreq", {31'd0, cpu_quiesce_req}, 32'd0);
    chk("t4_err_to_clr", {31'd0, err_timeout}, 32'd0);
    chk("t4_stay_idle", {31'd0, busy}, 32'd0);
    tick(1);
    chk("t4_err_cfg_pulse", {31'd0, err_cfg}, 32'd0);
    chk("t4_cfg_unchanged", {28'd0, clk_gate_en, clk_div_sel}, 32'hb);
    set_req(0, 1'b1, 3'd3, 1'b1);
    #1;
    chk("t4_ready_fast", {30'd0, req_if.req_ready}, 32'd1);
    tick(1);
    set_req(0, 1'b0, 3'd3, 1'b1);
    chk("t4_fast_done", {31'd0, done_pulse}, 32'd1);
    chk("t4_fast_noq", {31'd0, cpu_quiesce_req}, 32'd0);
    tick(1);
    chk("t4_fast_end", {30'd0, done_pulse, busy}, 32'd0);

    // 5) rst_done drops while in SWITCH.
    set_req(1, 1'b1, 3'd1, 1'b0);
    cpu_quiesce_ack = 1'b1;
    tick(1);
    set_req(1, 1'b0, 3'd1, 1'b0);
    tick(7);
    chk("t5_switch_div", {28'd0, clk_gate_en, clk_div_sel}, 32'h9);
    rst_done = 1'b0;
    set_req(0, 1'b1, 3'd2, 1'b0);
    tick(1);
    chk("t5_abort_idle", {31'd0, busy}, 32'd0);
    chk("t5_abort_cfg", {28'd0, clk_gate_en, clk_div_sel}, 32'd0);
    chk("t5_abort_qreq", {31'd0, cpu_quiesce_req}, 32'd0);
    chk("t5_owner_kept", {31'd0, owner}, 32'd1);
    chk("t5_no_ready", {30'd0, req_if.req_ready}, 32'd0);
    set_req(0, 1'b0, 3'd2, 1'b0);
    rst_done = 1'b1;
    cpu_quiesce_ack = 1'b0;
    tick(1);

    // 6) test_mode blocks acceptance; rst mid-UNGATE clears everything.
    test_mode = 1'b1;
    set_req(1, 1'b1, 3'd2, 1'b1);
    #1;
    chk("t6_tm_ready", {30'd0, req_if.req_ready}, 32'd0);
    tick(2);
    chk("t6_tm_idle", {31'd0, busy}, 32'd0);
    test_mode = 1'b0;
    #1;
    chk("t6_ready", {30'd0, req_if.req_ready}, 32'd2);
    cpu_quiesce_ack = 1'b1;
    tick(1);
    set_req(1, 1'b0, 3'd2, 1'b1);
    chk("t6_owner", {31'd0, owner}, 32'd1);
    tick(23);
    chk("t6_ungate_state", {27'd0, cpu_quiesce_req, clk_gate_en, clk_div_sel}, 32'h1a);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_out", {26'd0, cpu_quiesce_req, clk_gate_en, busy, done_pulse, err_timeout, err_cfg},
        32'd0);
    chk("t6_rst_div", {29'd0, clk_div_sel}, 32'd0);
    chk("t6_rst_owner", {31'd0, owner}, 32'd0);
    rst = 1'b0;
    cpu_quiesce_ack = 1'b0;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
